// File: rtl/x_mux_pipe.sv
// x_mux_pipe: X operand multiplexer with optional opmode and output
// registers, plus an illegal-opmode event monitor.
module x_mux_pipe #(
    parameter int AW        = 30,
    parameter int BW        = 18,
    parameter int MW        = 43,
    parameter int PW        = 48,
    parameter int XREG      = 1,
    parameter int OPMODEREG = 1,
    parameter int ERRW      = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            CE_X,
    input  logic            CE_OPMODE,
    input  logic            VALID_IN,
    input  logic            M_SIGNED,
    input  logic            ERR_CLR,
    input  logic [AW-1:0]   A,
    input  logic [BW-1:0]   B,
    input  logic [MW-1:0]   M,
    input  logic [PW-1:0]   P,
    input  logic [3:0]      OP_MODE,
    output logic [PW-1:0]   X_MUX_OUT,
    output logic            VALID_OUT,
    output logic            ERR_FLAG,
    output logic [ERRW-1:0] ERR_CNT
);

    // Reject configurations the datapath cannot represent.
    if (PW != AW + BW) begin : g_bad_pw
        $error("x_mux_pipe: PW must equal AW+BW");
    end
    if (MW > PW) begin : g_bad_mw
        $error("x_mux_pipe: MW must not exceed PW");
    end

    logic [3:0]    opm;
    logic [PW-1:0] m_ext;
    logic [PW-1:0] sel;
    logic          illegal;
    logic          err_ev;

    // Effective opmode: registered or taken straight from the port.
    if (OPMODEREG != 0) begin : g_opm_reg
        logic [3:0] opm_q;
        logic [3:0] opm_d;

        // Next opmode: load when enabled, otherwise hold.
        always_comb begin
            opm_d = opm_q;
            if (CE_OPMODE) begin
                opm_d = OP_MODE;
            end
        end

        // Opmode register, cleared by reset.
        always_ff @(posedge CLK) begin
            if (RST) begin
                opm_q <= 4'b0000;
            end else begin
                opm_q <= opm_d;
            end
        end

        assign opm = opm_q;
    end else begin : g_opm_comb
        assign opm = OP_MODE;
    end

    // Sign- or zero-extend the multiplier product to full width.
    if (MW < PW) begin : g_m_ext
        assign m_ext = {{(PW-MW){M_SIGNED & M[MW-1]}}, M};
    end else begin : g_m_full
        assign m_ext = M;
    end

    // Operand selection; 01 is only legal as the full 4'b0101 code.
    always_comb begin
        sel     = '0;
        illegal = 1'b0;
        unique case (opm[1:0])
            2'b00: sel = '0;
            2'b01: begin
                if (opm[3:2] == 2'b01) begin
                    sel = m_ext;
                end else begin
                    illegal = 1'b1;
                end
            end
            2'b10: sel = P;
            2'b11: sel = {A, B};
        endcase
    end

    assign err_ev = VALID_IN & illegal;

    logic [ERRW-1:0] err_cnt_q;
    logic [ERRW-1:0] err_cnt_d;
    logic            err_flag_q;
    logic            err_flag_d;

    // Error monitor next state: clear wins, count saturates.
    always_comb begin
        err_cnt_d  = err_cnt_q;
        err_flag_d = err_flag_q;
        if (ERR_CLR) begin
            err_cnt_d  = '0;
            err_flag_d = 1'b0;
        end else if (err_ev) begin
            err_flag_d = 1'b1;
            if (err_cnt_q != {ERRW{1'b1}}) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end
    end

    // Error monitor state, independent of the output enable.
    always_ff @(posedge CLK) begin
        if (RST) begin
            err_cnt_q  <= '0;
            err_flag_q <= 1'b0;
        end else begin
            err_cnt_q  <= err_cnt_d;
            err_flag_q <= err_flag_d;
        end
    end

    assign ERR_CNT  = err_cnt_q;
    assign ERR_FLAG = err_flag_q;

    // Output stage: registered under CE_X, or a straight pass-through.
    if (XREG != 0) begin : g_x_reg
        logic [PW-1:0] x_q;
        logic [PW-1:0] x_d;
        logic          vld_q;
        logic          vld_d;

        // Next output: load selection and qualifier when enabled.
        always_comb begin
            x_d   = x_q;
            vld_d = vld_q;
            if (CE_X) begin
                x_d   = sel;
                vld_d = VALID_IN;
            end
        end

        // Output register, cleared by reset.
        always_ff @(posedge CLK) begin
            if (RST) begin
                x_q   <= '0;
                vld_q <= 1'b0;
            end else begin
                x_q   <= x_d;
                vld_q <= vld_d;
            end
        end

        assign X_MUX_OUT = x_q;
        assign VALID_OUT = vld_q;
    end else begin : g_x_comb
        assign X_MUX_OUT = sel;
        assign VALID_OUT = VALID_IN;
    end

endmodule
